// File: rtl/arb_mux_reg_pkg.sv
// Shared constants and helpers for the registered arbitrating selector.
package arb_mux_reg_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Round-robin / fixed-select grant generator.
// Owns the rotating priority pointer.
module rr_arbiter
  import arb_mux_reg_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW-1:0] ptr;
  logic            found;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (mode == MODE_FIXED) begin
      // sel beyond N-1 simply matches nothing
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = SELW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && mode == MODE_RR) begin
      ptr <= SELW'((int'(grant_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-input registered selector with valid/ready handshakes,
// round-robin or fixed-select arbitration and one output stage.
module arb_mux_reg
  import arb_mux_reg_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32,
  localparam int SELW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic            load_en;
  logic            xfer;

  assign load_en  = !out_valid || out_ready;
  assign in_ready = {N{rst_n && load_en}} & grant;
  assign xfer     = |(in_valid & in_ready);

  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .mode      (mode),
    .sel       (sel),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[int'(gidx)*W +: W];
        out_chan <= gidx;
      end
    end
  end

endmodule
